// File: rtl/decode_seq_pkg.sv
`default_nettype none
// decode_seq_pkg: shared state/owner encodings, SRAM widths and default timings. rev 1.0
package decode_seq_pkg;

  localparam int SRAM_AW          = 18;
  localparam int SRAM_DW          = 16;
  localparam int UART_TIMEOUT_DEF = 50_000_000;
  localparam int GUARD_CYCLES_DEF = 2;
  localparam int WDOG_CYCLES_DEF  = 2**26 - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UART_RX = 3'd1,
    S_GUARD   = 3'd2,
    S_IDCT    = 3'd3,
    S_US_CSC  = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    OWN_NONE  = 3'd0,
    OWN_VGA   = 3'd1,
    OWN_UART  = 3'd2,
    OWN_IDCT  = 3'd3,
    OWN_USCSC = 3'd4
  } owner_t;

  function automatic owner_t state_owner(input seq_state_t st);
    case (st)
      S_IDLE, S_DONE: return OWN_VGA;
      S_UART_RX:      return OWN_UART;
      S_IDCT:         return OWN_IDCT;
      S_US_CSC:       return OWN_USCSC;
      default:        return OWN_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_sequencer_if.sv
`default_nettype none
// decode_sequencer_if: requester buses, stage handshakes and SRAM port of the sequencer. rev 1.0
interface decode_sequencer_if;
  import decode_seq_pkg::*;

  logic [SRAM_AW-1:0] uart_addr;
  logic [SRAM_DW-1:0] uart_wdata;
  logic               uart_we_n;
  logic [SRAM_AW-1:0] vga_addr;
  logic [SRAM_AW-1:0] idct_addr;
  logic [SRAM_DW-1:0] idct_wdata;
  logic               idct_we_n;
  logic [SRAM_AW-1:0] uscsc_addr;
  logic [SRAM_DW-1:0] uscsc_wdata;
  logic               uscsc_we_n;
  logic               idct_complete;
  logic               uscsc_complete;
  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_wdata;
  logic               sram_we_n;
  logic               uart_rx_initialize;
  logic               uart_rx_enable;
  logic               vga_enable;
  logic               idct_enable;
  logic               uscsc_enable;

  modport master (
    input  uart_addr, uart_wdata, uart_we_n, vga_addr,
    input  idct_addr, idct_wdata, idct_we_n,
    input  uscsc_addr, uscsc_wdata, uscsc_we_n,
    input  idct_complete, uscsc_complete,
    output sram_addr, sram_wdata, sram_we_n,
    output uart_rx_initialize, uart_rx_enable,
    output vga_enable, idct_enable, uscsc_enable
  );

  modport slave (
    output uart_addr, uart_wdata, uart_we_n, vga_addr,
    output idct_addr, idct_wdata, idct_we_n,
    output uscsc_addr, uscsc_wdata, uscsc_we_n,
    output idct_complete, uscsc_complete,
    input  sram_addr, sram_wdata, sram_we_n,
    input  uart_rx_initialize, uart_rx_enable,
    input  vga_enable, idct_enable, uscsc_enable
  );

endinterface
`default_nettype wire

// File: rtl/sram_owner_mux.sv
`default_nettype none
// sram_owner_mux: static SRAM port multiplexer; no owner means address 0 with writes off. rev 1.0
module sram_owner_mux
  import decode_seq_pkg::*;
(
  input  owner_t             i_owner,
  input  logic [SRAM_AW-1:0] i_vga_addr,
  input  logic [SRAM_AW-1:0] i_uart_addr,
  input  logic [SRAM_DW-1:0] i_uart_wdata,
  input  logic               i_uart_we_n,
  input  logic [SRAM_AW-1:0] i_idct_addr,
  input  logic [SRAM_DW-1:0] i_idct_wdata,
  input  logic               i_idct_we_n,
  input  logic [SRAM_AW-1:0] i_uscsc_addr,
  input  logic [SRAM_DW-1:0] i_uscsc_wdata,
  input  logic               i_uscsc_we_n,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [SRAM_DW-1:0] o_sram_wdata,
  output logic               o_sram_we_n
);

  always_comb begin
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    o_sram_we_n  = 1'b1;
    case (i_owner)
      OWN_VGA: o_sram_addr = i_vga_addr;
      OWN_UART: begin
        o_sram_addr  = i_uart_addr;
        o_sram_wdata = i_uart_wdata;
        o_sram_we_n  = i_uart_we_n;
      end
      OWN_IDCT: begin
        o_sram_addr  = i_idct_addr;
        o_sram_wdata = i_idct_wdata;
        o_sram_we_n  = i_idct_we_n;
      end
      OWN_USCSC: begin
        o_sram_addr  = i_uscsc_addr;
        o_sram_wdata = i_uscsc_wdata;
        o_sram_we_n  = i_uscsc_we_n;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_sequencer.sv
`default_nettype none
// decode_sequencer: UART -> IDCT -> US_CSC -> VGA milestone scheduler and SRAM owner. rev 1.0
// Optional per-stage watchdog and S_ERROR path: define SEQ_STAGE_WATCHDOG_EN.
module decode_sequencer
  import decode_seq_pkg::*;
#(
  parameter int UART_TIMEOUT = UART_TIMEOUT_DEF,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int WDOG_CYCLES  = WDOG_CYCLES_DEF
) (
  input  logic               CLOCK_50_I,
  input  logic               resetn,
  input  logic               UART_RX_I,
  decode_sequencer_if.master bus,
  output logic [2:0]         seq_state,
  output logic               seq_error
);

  localparam int TIMER_W = $clog2(UART_TIMEOUT + 1);

  seq_state_t         r_state;
  seq_state_t         r_next_stage;
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_guard;
  logic               r_vga_en;
  logic               r_init;
  logic               r_rx_en;
  logic               r_idct_en;
  logic               r_uscsc_en;
  logic               w_guard_done;
  logic               w_cmp_busy;
  logic               w_wdog_hit;
  owner_t             w_owner;

  assign w_guard_done = (r_guard == 3'(GUARD_CYCLES - 1));
  // A stage is only (re)enabled once no stale complete level is visible.
  assign w_cmp_busy   = bus.idct_complete | bus.uscsc_complete;

`ifdef SEQ_STAGE_WATCHDOG_EN
  logic [25:0] r_wdog;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn)
      r_wdog <= '0;
    else if (r_state == S_IDCT || r_state == S_US_CSC)
      r_wdog <= r_wdog + 26'd1;
    else
      r_wdog <= '0;
  end

  assign w_wdog_hit = (r_wdog == 26'(WDOG_CYCLES - 1));
  assign seq_error  = (r_state == S_ERROR);
`else
  logic w_unused_wdog;
  assign w_unused_wdog = ^WDOG_CYCLES;
  assign w_wdog_hit    = 1'b0;
  assign seq_error     = 1'b0;
`endif

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_next_stage <= S_IDLE;
      r_timer      <= '0;
      r_guard      <= '0;
      r_vga_en     <= 1'b1;
      r_init       <= 1'b0;
      r_rx_en      <= 1'b0;
      r_idct_en    <= 1'b0;
      r_uscsc_en   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_vga_en <= 1'b1;
          if (!UART_RX_I) begin
            r_init   <= 1'b1;
            r_vga_en <= 1'b0;
            r_timer  <= '0;
            r_state  <= S_UART_RX;
          end
        end
        S_UART_RX: begin
          if (r_init) begin
            r_init  <= 1'b0;
            r_rx_en <= 1'b1;
          end
          if (!bus.uart_we_n)
            r_timer <= '0;
          else if (r_timer == TIMER_W'(UART_TIMEOUT - 1)) begin
            r_rx_en      <= 1'b0;
            r_next_stage <= S_IDCT;
            r_guard      <= '0;
            r_state      <= S_GUARD;
          end else
            r_timer <= r_timer + TIMER_W'(1);
        end
        S_GUARD: begin
          if (!w_guard_done)
            r_guard <= r_guard + 3'd1;
          else if (!w_cmp_busy) begin
            r_state <= r_next_stage;
            case (r_next_stage)
              S_IDCT:   r_idct_en  <= 1'b1;
              S_US_CSC: r_uscsc_en <= 1'b1;
              S_DONE:   r_vga_en   <= 1'b1;
              default:  ;
            endcase
          end
        end
        S_IDCT: begin
          if (bus.idct_complete) begin
            r_idct_en    <= 1'b0;
            r_next_stage <= S_US_CSC;
            r_guard      <= '0;
            r_state      <= S_GUARD;
          end else if (w_wdog_hit) begin
            r_idct_en <= 1'b0;
            r_state   <= S_ERROR;
          end
        end
        S_US_CSC: begin
          if (bus.uscsc_complete) begin
            r_uscsc_en   <= 1'b0;
            r_next_stage <= S_DONE;
            r_guard      <= '0;
            r_state      <= S_GUARD;
          end else if (w_wdog_hit) begin
            r_uscsc_en <= 1'b0;
            r_state    <= S_ERROR;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERROR: r_vga_en <= 1'b0;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_owner = state_owner(r_state);

  sram_owner_mux u_mux (
    .i_owner       (w_owner),
    .i_vga_addr    (bus.vga_addr),
    .i_uart_addr   (bus.uart_addr),
    .i_uart_wdata  (bus.uart_wdata),
    .i_uart_we_n   (bus.uart_we_n),
    .i_idct_addr   (bus.idct_addr),
    .i_idct_wdata  (bus.idct_wdata),
    .i_idct_we_n   (bus.idct_we_n),
    .i_uscsc_addr  (bus.uscsc_addr),
    .i_uscsc_wdata (bus.uscsc_wdata),
    .i_uscsc_we_n  (bus.uscsc_we_n),
    .o_sram_addr   (bus.sram_addr),
    .o_sram_wdata  (bus.sram_wdata),
    .o_sram_we_n   (bus.sram_we_n)
  );

  assign bus.vga_enable         = r_vga_en;
  assign bus.uart_rx_initialize = r_init;
  assign bus.uart_rx_enable     = r_rx_en;
  assign bus.idct_enable        = r_idct_en;
  assign bus.uscsc_enable       = r_uscsc_en;
  assign seq_state              = r_state;

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// tb_decode_sequencer: scoreboard bench walking the full decode pipeline and its corner cases.
module tb_decode_sequencer;
  import decode_seq_pkg::*;

  localparam int T_UART  = 100;
  localparam int T_GUARD = 2;
  localparam int T_WDOG  = 50;

  // enable vector {vga, initialize, rx_enable, idct, uscsc}
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_VGA  = 5'b10000;
  localparam logic [4:0] EN_INIT = 5'b01000;
  localparam logic [4:0] EN_RX   = 5'b00100;
  localparam logic [4:0] EN_IDCT = 5'b00010;
  localparam logic [4:0] EN_USC  = 5'b00001;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn;
  logic        UART_RX_I;
  logic [2:0]  seq_state;
  logic        seq_error;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [43:0] exp_q[$];
  logic [43:0] o, e;

  decode_sequencer_if bus();

  decode_sequencer #(
    .UART_TIMEOUT(T_UART),
    .GUARD_CYCLES(T_GUARD),
    .WDOG_CYCLES (T_WDOG)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn    (resetn),
    .UART_RX_I (UART_RX_I),
    .bus       (bus),
    .seq_state (seq_state),
    .seq_error (seq_error)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  // Expected observable vector for a given state/enables, with the SRAM port chosen by owner.
  function automatic logic [43:0] exp_vec(input seq_state_t st, input logic [4:0] en, input logic err);
    logic [17:0] a;
    logic [15:0] d;
    logic        w;
    a = '0;
    d = '0;
    w = 1'b1;
    case (st)
      S_IDLE, S_DONE: a = bus.vga_addr;
      S_UART_RX: begin a = bus.uart_addr;  d = bus.uart_wdata;  w = bus.uart_we_n;  end
      S_IDCT:    begin a = bus.idct_addr;  d = bus.idct_wdata;  w = bus.idct_we_n;  end
      S_US_CSC:  begin a = bus.uscsc_addr; d = bus.uscsc_wdata; w = bus.uscsc_we_n; end
      default: ;
    endcase
    return {st, en, err, w, a, d};
  endfunction

  function automatic logic [43:0] obs_vec();
    return {seq_state, bus.vga_enable, bus.uart_rx_initialize, bus.uart_rx_enable,
            bus.idct_enable, bus.uscsc_enable, seq_error, bus.sram_we_n,
            bus.sram_addr, bus.sram_wdata};
  endfunction

  task automatic step();
    @(posedge CLOCK_50_I);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    exp_q.push_back(exp_vec(S_IDLE, EN_VGA, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_held: got %h expected %h", o, e); end
    resetn = 1'b1;
    exp_q.push_back(exp_vec(S_IDLE, EN_VGA, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_idle: got %h expected %h", o, e); end
  endtask

  task automatic test_uart_start();
    UART_RX_I = 1'b0;
    exp_q.push_back(exp_vec(S_UART_RX, EN_INIT, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL uart_start: got %h expected %h", o, e); end
    UART_RX_I = 1'b1;
    exp_q.push_back(exp_vec(S_UART_RX, EN_RX, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL uart_rx_enable: got %h expected %h", o, e); end
  endtask

  // Edges 2..6 after the start bit: completes outside their own stage must do nothing.
  task automatic test_ignore_complete();
    for (int i = 0; i < 5; i++) begin
      bus.idct_complete  = 1'b1;
      bus.uscsc_complete = i[0];
      exp_q.push_back(exp_vec(S_UART_RX, EN_RX, 1'b0));
      step();
      e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ignore_complete[%0d]: got %h expected %h", i, o, e); end
    end
    bus.idct_complete  = 1'b0;
    bus.uscsc_complete = 1'b0;
  endtask

  // Writes at edges 10 and 90; guard must start exactly T_UART edges after the last write.
  task automatic test_uart_timeout();
    for (int c = 7; c <= 192; c++) begin
      bus.uart_we_n  = (c == 10 || c == 90) ? 1'b0 : 1'b1;
      bus.uart_addr  = 18'(c + 1000);
      bus.uart_wdata = 16'(c * 3);
      if (c < 90 + T_UART)
        exp_q.push_back(exp_vec(S_UART_RX, EN_RX, 1'b0));
      else if (c < 90 + T_UART + T_GUARD)
        exp_q.push_back(exp_vec(S_GUARD, EN_NONE, 1'b0));
      else
        exp_q.push_back(exp_vec(S_IDCT, EN_IDCT, 1'b0));
      step();
      e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL uart_timeout[%0d]: got %h expected %h", c, o, e); end
    end
    bus.uart_we_n = 1'b1;
  endtask

  task automatic test_idct_handover();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_vec(S_IDCT, EN_IDCT, 1'b0));
      step();
      e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL idct_run[%0d]: got %h expected %h", i, o, e); end
    end
    for (int i = 0; i < 5; i++) begin
      bus.idct_complete = 1'b1;
      exp_q.push_back(exp_vec(S_GUARD, EN_NONE, 1'b0));
      step();
      e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL idct_guard_hold[%0d]: got %h expected %h", i, o, e); end
    end
    bus.idct_complete = 1'b0;
    bus.uscsc_addr    = 18'h0ABCD;
    bus.uscsc_wdata   = 16'hBEEF;
    bus.uscsc_we_n    = 1'b0;
    exp_q.push_back(exp_vec(S_US_CSC, EN_USC, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL uscsc_entry: got %h expected %h", o, e); end
    if (bus.sram_wdata !== 16'hBEEF || bus.sram_we_n !== 1'b0) begin
      n_bad++;
      $display("FAIL uscsc_write_pass: got wdata %h we_n %b expected BEEF 0", bus.sram_wdata, bus.sram_we_n);
    end
    n_cmp++;
  endtask

  task automatic test_uscsc_done();
    for (int i = 0; i < 2; i++) begin
      bus.idct_complete = 1'b1;
      exp_q.push_back(exp_vec(S_US_CSC, EN_USC, 1'b0));
      step();
      e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL uscsc_ignore_idct[%0d]: got %h expected %h", i, o, e); end
    end
    bus.idct_complete  = 1'b0;
    bus.uscsc_complete = 1'b1;
    exp_q.push_back(exp_vec(S_GUARD, EN_NONE, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL uscsc_complete: got %h expected %h", o, e); end
    bus.uscsc_complete = 1'b0;
    exp_q.push_back(exp_vec(S_GUARD, EN_NONE, 1'b0));
    exp_q.push_back(exp_vec(S_DONE, EN_VGA, 1'b0));
    exp_q.push_back(exp_vec(S_IDLE, EN_VGA, 1'b0));
    exp_q.push_back(exp_vec(S_IDLE, EN_VGA, 1'b0));
    for (int i = 0; i < 4; i++) begin
      step();
      e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL done_seq[%0d]: got %h expected %h", i, o, e); end
    end
    n_cmp++;
    if (bus.sram_addr !== 18'd146944) begin
      n_bad++; $display("FAIL vga_addr_pass: got %0d expected 146944", bus.sram_addr);
    end
  endtask

  // Restart from S_IDLE, then an asynchronous reset mid-receive.
  task automatic test_back_to_back();
    UART_RX_I = 1'b0;
    exp_q.push_back(exp_vec(S_UART_RX, EN_INIT, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL restart: got %h expected %h", o, e); end
    UART_RX_I = 1'b1;
    exp_q.push_back(exp_vec(S_UART_RX, EN_RX, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL restart_rx: got %h expected %h", o, e); end
    exp_q.push_back(exp_vec(S_IDLE, EN_VGA, 1'b0));
    #3 resetn = 1'b0;
    #1;
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL async_reset: got %h expected %h", o, e); end
    step();
    resetn = 1'b1;
    exp_q.push_back(exp_vec(S_IDLE, EN_VGA, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL post_reset_idle: got %h expected %h", o, e); end
  endtask

`ifdef SEQ_STAGE_WATCHDOG_EN
  task automatic test_watchdog();
    UART_RX_I = 1'b0;
    exp_q.push_back(exp_vec(S_UART_RX, EN_INIT, 1'b0));
    step();
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL wd_start: got %h expected %h", o, e); end
    UART_RX_I = 1'b1;
    for (int c = 1; c <= T_UART + T_GUARD; c++) begin
      if (c < T_UART)
        exp_q.push_back(exp_vec(S_UART_RX, EN_RX, 1'b0));
      else if (c < T_UART + T_GUARD)
        exp_q.push_back(exp_vec(S_GUARD, EN_NONE, 1'b0));
      else
        exp_q.push_back(exp_vec(S_IDCT, EN_IDCT, 1'b0));
      step();
      e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wd_lead[%0d]: got %h expected %h", c, o, e); end
    end
    for (int j = 1; j <= T_WDOG + 3; j++) begin
      if (j < T_WDOG)
        exp_q.push_back(exp_vec(S_IDCT, EN_IDCT, 1'b0));
      else
        exp_q.push_back(exp_vec(S_ERROR, EN_NONE, 1'b1));
      step();
      e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wd_count[%0d]: got %h expected %h", j, o, e); end
    end
    exp_q.push_back(exp_vec(S_IDLE, EN_VGA, 1'b0));
    resetn = 1'b0;
    #1;
    e = exp_q.pop_front(); o = obs_vec(); n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL wd_reset: got %h expected %h", o, e); end
    step();
    resetn = 1'b1;
    step();
  endtask
`endif

  initial begin
    resetn             = 1'b0;
    UART_RX_I          = 1'b1;
    bus.uart_addr      = '0;
    bus.uart_wdata     = '0;
    bus.uart_we_n      = 1'b1;
    bus.vga_addr       = 18'd146944;
    bus.idct_addr      = 18'h00123;
    bus.idct_wdata     = 16'h1234;
    bus.idct_we_n      = 1'b0;
    bus.uscsc_addr     = 18'h00456;
    bus.uscsc_wdata    = 16'h5678;
    bus.uscsc_we_n     = 1'b1;
    bus.idct_complete  = 1'b0;
    bus.uscsc_complete = 1'b0;
    #5;
    test_reset();
    test_uart_start();
    test_ignore_complete();
    test_uart_timeout();
    test_idct_handover();
    test_uscsc_done();
    test_back_to_back();
`ifdef SEQ_STAGE_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
